// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA pixel-rate divider, scan counters and registered sync decode
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] HS_FIRST = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_LAST  = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_LAST  = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : gen_bad_params
      $error("vga_sync_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end
  endgenerate

  logic [DIV_W-1:0] div;
  logic             div_wrap;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic [10:0]      h_ext;
  logic [10:0]      v_ext;

  assign div_wrap = (div == DIV_LAST);
  assign h_ext    = {1'b0, h_next};
  assign v_ext    = {1'b0, v_next};

  // Next-state scan position; every output below is decoded from it so all change together.
  always_comb begin
    h_next = pixel_x;
    v_next = pixel_y;
    if (div_wrap) begin
      if (pixel_x == H_LAST) begin
        h_next = 10'd0;
        v_next = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
      end else begin
        h_next = pixel_x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      p_tick     <= 1'b0;
      pixel_x    <= 10'd0;
      pixel_y    <= 10'd0;
      video_on   <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      frame_tick <= 1'b0;
    end else begin
      div        <= div_wrap ? '0 : div + DIV_W'(1);
      p_tick     <= div_wrap;
      pixel_x    <= h_next;
      pixel_y    <= v_next;
      video_on   <= (h_ext < H_VIS) && (v_ext < V_VIS);
      hsync      <= ((h_ext >= HS_FIRST) && (h_ext <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vsync      <= ((v_ext >= VS_FIRST) && (v_ext <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      // Only the step into (0,V_DISPLAY) qualifies; the held pixel clks that follow do not.
      frame_tick <= div_wrap && (h_next == 10'd0) && (v_ext == V_VIS);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed checks of vga_sync_gen at default and reduced timing
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic p_a, von_a, hs_a, vs_a, ft_a;
  logic p_b, von_b, hs_b, vs_b, ft_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clk(clk), .rst(rst_a), .p_tick(p_a), .pixel_x(x_a), .pixel_y(y_a),
    .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
  );

  // Small frame: 15x8 pixels, 3 clks/pixel, active-high sync -> 360 clks per frame.
  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(3), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .p_tick(p_b), .pixel_x(x_b), .pixel_y(y_b),
    .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
  );

  task automatic chk(input string name, input int t, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", name, t, act, exp);
    end
  endtask

  typedef struct {
    int   t;
    logic p;
    int   x;
    int   y;
    logic von;
    logic hs;
  } vec_t;

  vec_t vecs[16];

  int idx;
  int p_alt_err, hs_low_l0, p_cnt_l0, von_l0, ft_a_cnt, vs_a_low;
  int ft_b_cnt, ft_b_first, ft_b_second, vs_b_hi, hs_b_hi, von_b_cnt;

  initial begin
    vecs[0]  = '{1,    1'b0, 0,   0, 1'b1, 1'b1};
    vecs[1]  = '{2,    1'b1, 1,   0, 1'b1, 1'b1};
    vecs[2]  = '{3,    1'b0, 1,   0, 1'b1, 1'b1};
    vecs[3]  = '{4,    1'b1, 2,   0, 1'b1, 1'b1};
    vecs[4]  = '{1279, 1'b0, 639, 0, 1'b1, 1'b1};
    vecs[5]  = '{1280, 1'b1, 640, 0, 1'b0, 1'b1};
    vecs[6]  = '{1311, 1'b0, 655, 0, 1'b0, 1'b1};
    vecs[7]  = '{1312, 1'b1, 656, 0, 1'b0, 1'b0};
    vecs[8]  = '{1503, 1'b0, 751, 0, 1'b0, 1'b0};
    vecs[9]  = '{1504, 1'b1, 752, 0, 1'b0, 1'b1};
    vecs[10] = '{1598, 1'b1, 799, 0, 1'b0, 1'b1};
    vecs[11] = '{1599, 1'b0, 799, 0, 1'b0, 1'b1};
    vecs[12] = '{1600, 1'b1, 0,   1, 1'b1, 1'b1};
    vecs[13] = '{1601, 1'b0, 0,   1, 1'b1, 1'b1};
    vecs[14] = '{3200, 1'b1, 0,   2, 1'b1, 1'b1};
    vecs[15] = '{4600, 1'b1, 700, 2, 1'b0, 1'b0};

    p_alt_err = 0; hs_low_l0 = 0; p_cnt_l0 = 0; von_l0 = 0; ft_a_cnt = 0; vs_a_low = 0;
    ft_b_cnt = 0; ft_b_first = -1; ft_b_second = -1; vs_b_hi = 0; hs_b_hi = 0; von_b_cnt = 0;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_a_p", 0, p_a, 0);
    chk("rst_a_x", 0, x_a, 0);
    chk("rst_a_y", 0, y_a, 0);
    chk("rst_a_von", 0, von_a, 0);
    chk("rst_a_hs", 0, hs_a, 1);
    chk("rst_a_vs", 0, vs_a, 1);
    chk("rst_a_ft", 0, ft_a, 0);
    chk("rst_b_hs", 0, hs_b, 0);
    chk("rst_b_vs", 0, vs_b, 0);
    chk("rst_b_von", 0, von_b, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    idx = 0;
    for (int t = 1; t <= 4604; t++) begin
      @(posedge clk);
      #1;
      // Default-timing instance: table vectors plus line-0 statistics.
      if (t <= 4600) begin
        if (p_a !== ((t % 2) == 0)) p_alt_err++;
        if (ft_a) ft_a_cnt++;
        if (!vs_a) vs_a_low++;
        if (t < 1600) begin
          if (!hs_a) hs_low_l0++;
          if (von_a) von_l0++;
        end
        if (t <= 1600 && p_a) p_cnt_l0++;
      end
      if (idx < 16 && vecs[idx].t == t) begin
        chk("vec_p", t, p_a, vecs[idx].p);
        chk("vec_x", t, x_a, vecs[idx].x);
        chk("vec_y", t, y_a, vecs[idx].y);
        chk("vec_von", t, von_a, vecs[idx].von);
        chk("vec_hs", t, hs_a, vecs[idx].hs);
        idx++;
      end
      if (t == 4600) rst_a = 1'b1;
      if (t == 4601) begin
        chk("mid_rst_x", t, x_a, 0);
        chk("mid_rst_y", t, y_a, 0);
        chk("mid_rst_von", t, von_a, 0);
        chk("mid_rst_p", t, p_a, 0);
        chk("mid_rst_hs", t, hs_a, 1);
        rst_a = 1'b0;
      end
      if (t == 4602) begin
        chk("rel_a_von", t, von_a, 1);
        chk("rel_a_x0", t, x_a, 0);
        chk("rel_a_p0", t, p_a, 0);
      end
      if (t == 4603) begin
        chk("rel_a_x1", t, x_a, 1);
        chk("rel_a_p1", t, p_a, 1);
      end

      // Reduced-timing instance: two whole frames, then a reset inside vsync.
      if (t <= 720) begin
        if (ft_b) begin
          ft_b_cnt++;
          if (ft_b_first < 0) ft_b_first = t;
          else if (ft_b_second < 0) ft_b_second = t;
        end
        if (vs_b) vs_b_hi++;
        if (hs_b) hs_b_hi++;
        if (von_b) von_b_cnt++;
      end
      if (t == 180) begin
        chk("b_ft_x", t, x_b, 0);
        chk("b_ft_y", t, y_b, 4);
      end
      if (t == 359) begin
        chk("b_wrap_pre_x", t, x_b, 14);
        chk("b_wrap_pre_y", t, y_b, 7);
      end
      if (t == 360) begin
        chk("b_wrap_x", t, x_b, 0);
        chk("b_wrap_y", t, y_b, 0);
        chk("b_wrap_von", t, von_b, 1);
        chk("b_wrap_p", t, p_b, 1);
      end
      if (t == 978) begin
        chk("b_pre_rst_hs", t, hs_b, 1);
        chk("b_pre_rst_vs", t, vs_b, 1);
        rst_b = 1'b1;
      end
      if (t == 979) begin
        chk("b_rst_x", t, x_b, 0);
        chk("b_rst_y", t, y_b, 0);
        chk("b_rst_hs", t, hs_b, 0);
        chk("b_rst_vs", t, vs_b, 0);
        chk("b_rst_p", t, p_b, 0);
        rst_b = 1'b0;
      end
      if (t == 980) begin
        chk("b_rel_von", t, von_b, 1);
        chk("b_rel_p1", t, p_b, 0);
      end
      if (t == 981) chk("b_rel_p2", t, p_b, 0);
      if (t == 982) begin
        chk("b_rel_p3", t, p_b, 1);
        chk("b_rel_x", t, x_b, 1);
      end
    end

    chk("vec_all_applied", 0, idx, 16);
    chk("a_p_alternation_errs", 0, p_alt_err, 0);
    chk("a_p_ticks_line0", 0, p_cnt_l0, 800);
    chk("a_hs_low_clks_line0", 0, hs_low_l0, 192);
    chk("a_von_clks_line0", 0, von_l0, 1279);
    chk("a_no_frame_tick", 0, ft_a_cnt, 0);
    chk("a_no_vsync", 0, vs_a_low, 0);
    chk("b_ft_count", 0, ft_b_cnt, 2);
    chk("b_ft_first", 0, ft_b_first, 180);
    chk("b_ft_period", 0, ft_b_second - ft_b_first, 360);
    chk("b_vs_clks", 0, vs_b_hi, 180);
    chk("b_hs_clks", 0, hs_b_hi, 144);
    chk("b_von_clks", 0, von_b_cnt, 192);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
